// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared encodings for the AXI slave write path:
//   - burst type encodings (FIXED / INCR / WRAP / reserved)
//   - write response encodings (OKAY / SLVERR)
//   - write-controller FSM state encoding
//   - wrap_len_ok(): legal WRAP burst length check (2, 4, 8 or 16 beats)
// -----------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // A WRAP burst must be 2, 4, 8 or 16 beats long (awlen = beats - 1).
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axi_addr.sv
// -----------------------------------------------------------------------------
// axi_addr
// Combinational AXI next-beat address calculator.
// Ports:
//   i_last_addr  [AW-1:0]  address of the beat just transferred
//   i_size       [2:0]     log2 bytes per beat
//   i_burst      [1:0]     00 FIXED, 01 INCR, 10 WRAP, 11 treated as FIXED
//   i_len        [7:0]     beats minus 1 (sets the WRAP window)
//   o_next_addr  [AW-1:0]  address of the following beat (modulo 2^AW)
// INCR and WRAP align the current address down to the beat size before
// stepping, so an unaligned first beat is followed by aligned beats.
// -----------------------------------------------------------------------------
module axi_addr #(
    parameter int AW = 12
) (
    input  logic [AW-1:0] i_last_addr,
    input  logic [2:0]    i_size,
    input  logic [1:0]    i_burst,
    input  logic [7:0]    i_len,
    output logic [AW-1:0] o_next_addr
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] incr_s;
    logic [AW-1:0] align_mask_s;
    logic [AW-1:0] aligned_s;
    logic [AW-1:0] stepped_s;
    logic [AW-1:0] wrap_mask_s;

    // Step the size-aligned address by one beat; WRAP keeps the upper bits
    // of the window and only lets the offset inside the window advance.
    always_comb begin
        incr_s       = ONE << i_size;
        align_mask_s = incr_s - ONE;
        aligned_s    = i_last_addr & ~align_mask_s;
        stepped_s    = aligned_s + incr_s;
        wrap_mask_s  = (({{(AW-8){1'b0}}, i_len} + ONE) << i_size) - ONE;
        case (i_burst)
            2'b00:   o_next_addr = i_last_addr;
            2'b01:   o_next_addr = stepped_s;
            2'b10:   o_next_addr = (i_last_addr & ~wrap_mask_s) | (stepped_s & wrap_mask_s);
            default: o_next_addr = i_last_addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// axi_wr_burst_ctrl
// AXI slave write-channel controller: accepts one AW burst descriptor, then
// len+1 W beats (one memory write pulse per beat, one cycle after the beat
// handshake), then returns a single B response.
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   i_awaddr/len/size/burst        AW descriptor, i_awvalid / o_awready
//   i_wdata/wstrb/wlast            W beat, i_wvalid / o_wready
//   o_bresp, o_bvalid / i_bready   B response (OKAY or SLVERR)
//   o_mem_we/addr/wdata/wstrb      registered memory write port
// Errors (reserved burst, oversize beat, illegal WRAP length, misplaced
// wlast) suppress memory writes from the point they are known and turn the
// response into SLVERR; the burst still consumes exactly len+1 beats.
// -----------------------------------------------------------------------------
module axi_wr_burst_ctrl
    import axi_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   i_awaddr,
    input  logic [7:0]      i_awlen,
    input  logic [2:0]      i_awsize,
    input  logic [1:0]      i_awburst,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wlast,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wstrb
);

    localparam int         NB       = DW / 8;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(NB));

    state_e             state_q;
    logic [AW-1:0]      cur_addr_q;
    logic [7:0]         len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [7:0]         beat_cnt_q;
    logic               err_q;

    logic               awready_q;
    logic               wready_q;
    logic               bvalid_q;
    logic [1:0]         bresp_q;
    logic               mem_we_q;
    logic [AW-1:0]      mem_addr_q;
    logic [DW-1:0]      mem_wdata_q;
    logic [DW/8-1:0]    mem_wstrb_q;

    logic [AW-1:0]      cur_addr_d;
    logic [1:0]         addr_burst_s;
    logic               aw_hs_s;
    logic               w_hs_s;
    logic               last_beat_s;
    logic               wlast_err_s;
    logic               aw_err_s;
    logic               err_d;

    // Handshake qualifiers, descriptor checks and the error flag update.
    always_comb begin
        aw_hs_s     = i_awvalid & awready_q;
        w_hs_s      = i_wvalid & wready_q;
        last_beat_s = (beat_cnt_q == len_q);
        wlast_err_s = (i_wlast != last_beat_s);
        err_d       = err_q | wlast_err_s;
        if (i_awburst == BURST_RSVD) begin
            aw_err_s = 1'b1;
        end else if (i_awsize > SIZE_MAX) begin
            aw_err_s = 1'b1;
        end else if ((i_awburst == BURST_WRAP) && !wrap_len_ok(i_awlen)) begin
            aw_err_s = 1'b1;
        end else begin
            aw_err_s = 1'b0;
        end
        // A reserved burst type must not move the address.
        if (burst_q == BURST_RSVD) begin
            addr_burst_s = BURST_FIXED;
        end else begin
            addr_burst_s = burst_q;
        end
    end

    axi_addr #(
        .AW (AW)
    ) u_axi_addr (
        .i_last_addr (cur_addr_q),
        .i_size      (size_q),
        .i_burst     (addr_burst_s),
        .i_len       (len_q),
        .o_next_addr (cur_addr_d)
    );

    // Burst FSM with all outputs registered; mem_we is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= {AW{1'b0}};
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'b00;
            beat_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            mem_wstrb_q <= {NB{1'b0}};
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        cur_addr_q <= i_awaddr;
                        len_q      <= i_awlen;
                        size_q     <= i_awsize;
                        burst_q    <= i_awburst;
                        beat_cnt_q <= 8'd0;
                        err_q      <= aw_err_s;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        state_q    <= ST_DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_hs_s) begin
                        // The write uses the error state known before this beat.
                        mem_we_q    <= ~err_q;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= i_wdata;
                        mem_wstrb_q <= i_wstrb;
                        cur_addr_q  <= cur_addr_d;
                        beat_cnt_q  <= beat_cnt_q + 8'd1;
                        err_q       <= err_d;
                        if (last_beat_s) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid_q && i_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_awready   = awready_q;
    assign o_wready    = wready_q;
    assign o_bvalid    = bvalid_q;
    assign o_bresp     = bresp_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_burst_ctrl
// Scoreboard bench: the stimulus thread pushes expected memory writes and
// B responses (computed from burst arithmetic) into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_axi_wr_burst_ctrl;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] i_awaddr;
    logic [7:0]  i_awlen;
    logic [2:0]  i_awsize;
    logic [1:0]  i_awburst;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wlast;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;
    logic        o_mem_we;
    logic [11:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_exp_t    exp_mem[$];
    logic [1:0]  exp_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    axi_wr_burst_ctrl #(.AW(12), .DW(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_awaddr    (i_awaddr),
        .i_awlen     (i_awlen),
        .i_awsize    (i_awsize),
        .i_awburst   (i_awburst),
        .i_awvalid   (i_awvalid),
        .o_awready   (o_awready),
        .i_wdata     (i_wdata),
        .i_wstrb     (i_wstrb),
        .i_wlast     (i_wlast),
        .i_wvalid    (i_wvalid),
        .o_wready    (o_wready),
        .o_bresp     (o_bresp),
        .o_bvalid    (o_bvalid),
        .i_bready    (i_bready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: address of beat i from the AXI burst rules.
    function automatic logic [11:0] model_addr(input int start, input int len, input int size,
                                               input int burst, input int i);
        int nb;
        int a0;
        int bnd;
        int base;
        nb = 1 << size;
        a0 = start - (start % nb);
        if (i == 0 || burst == 0 || burst == 3) return 12'(start);
        if (burst == 1) return 12'((a0 + i * nb) % 4096);
        bnd  = (len + 1) * nb;
        base = start - (start % bnd);
        return 12'(base + ((a0 - base + i * nb) % bnd));
    endfunction

    function automatic logic model_aw_err(input int len, input int size, input int burst);
        if (burst == 3) return 1'b1;
        if ((1 << size) > 4) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: compares memory writes and B responses against the queues.
    logic       prev_bvalid = 1'b0;
    logic       prev_bhs    = 1'b0;
    logic [1:0] prev_bresp  = 2'b00;
    always @(negedge clk) begin
        mem_exp_t   e;
        logic [1:0] eb;
        logic       bhs;
        if (o_mem_we === 1'b1) begin
            if (exp_mem.size() == 0) begin
                fail_now("mem_we_unexpected");
            end else begin
                e = exp_mem.pop_front();
                chk("mem_addr", 64'(o_mem_addr), 64'(e.addr));
                chk("mem_wdata", 64'(o_mem_wdata), 64'(e.data));
                chk("mem_wstrb", 64'(o_mem_wstrb), 64'(e.strb));
                chk("mem_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        bhs = (o_bvalid === 1'b1) && (i_bready === 1'b1);
        if (prev_bvalid && !prev_bhs && rstn) begin
            chk("bvalid_hold", 64'(o_bvalid), 64'd1);
            chk("bresp_hold", 64'(o_bresp), 64'(prev_bresp));
        end
        if (bhs) begin
            if (exp_b.size() == 0) begin
                fail_now("bresp_unexpected");
            end else begin
                eb = exp_b.pop_front();
                chk("bresp", 64'(o_bresp), 64'(eb));
            end
        end
        prev_bvalid = rstn ? (o_bvalid === 1'b1) : 1'b0;
        prev_bhs    = bhs;
        prev_bresp  = o_bresp;
    end

    // All tasks start and end just after a rising edge.
    task automatic do_aw(input logic [11:0] a, input int len, input int size, input int burst);
        int n;
        i_awaddr  = a;
        i_awlen   = 8'(len);
        i_awsize  = 3'(size);
        i_awburst = 2'(burst);
        i_awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_awready === 1'b1) break;
            n++;
            if (n > 50) begin
                fail_now("aw_ready_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l,
                        input int gap, output int hs_cyc);
        int n;
        i_wvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        i_wdata  = d;
        i_wstrb  = s;
        i_wlast  = l;
        i_wvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_wready === 1'b1) break;
            n++;
            if (n > 50) begin
                fail_now("w_ready_timeout");
                break;
            end
        end
        hs_cyc = cyc + 1;
        chk("bvalid_during_data", 64'(o_bvalid), 64'd0);
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
    endtask

    task automatic do_b(input int delay);
        int n;
        i_bready = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_bvalid === 1'b1) break;
            n++;
            if (n > 50) begin
                fail_now("bvalid_timeout");
                break;
            end
        end
        chk("awready_in_resp", 64'(o_awready), 64'd0);
        repeat (delay) begin
            @(negedge clk);
            chk("awready_in_resp_stall", 64'(o_awready), 64'd0);
        end
        @(posedge clk);
        #1;
        i_bready = 1'b1;
        @(posedge clk);
        #1;
        i_bready = 1'b0;
        @(negedge clk);
        chk("bvalid_after_bhs", 64'(o_bvalid), 64'd0);
        chk("awready_after_bhs", 64'(o_awready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(o_awready), 64'd0);
        chk({tag, "_wready"}, 64'(o_wready), 64'd0);
        chk({tag, "_bvalid"}, 64'(o_bvalid), 64'd0);
        chk({tag, "_bresp"}, 64'(o_bresp), 64'd0);
        chk({tag, "_mem_we"}, 64'(o_mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(o_mem_wdata), 64'd0);
        chk({tag, "_mem_wstrb"}, 64'(o_mem_wstrb), 64'd0);
    endtask

    // gap < 0 means a random 0..2 cycle gap before each beat;
    // bad_last flips wlast on that beat; rst_after aborts after that many beats.
    task automatic run_burst(input int start, input int len, input int size, input int burst,
                             input int gap, input int bdelay, input int bad_last, input int rst_after);
        logic        err;
        logic        last;
        logic [31:0] d;
        logic [3:0]  s;
        int          g;
        int          hs;
        mem_exp_t    e;
        err = model_aw_err(len, size, burst);
        do_aw(12'(start), len, size, burst);
        for (int i = 0; i <= len; i++) begin
            if (i == rst_after) begin
                rstn = 1'b0;
                @(posedge clk);
                #1;
                @(negedge clk);
                chk_all_zero("midburst_reset");
                @(posedge clk);
                #1;
                rstn = 1'b1;
                return;
            end
            g    = (gap < 0) ? $urandom_range(2, 0) : gap;
            d    = $urandom;
            s    = 4'($urandom_range(15, 0));
            last = (i == len);
            if (i == bad_last) last = ~last;
            do_w(d, s, last, g, hs);
            if (!err) begin
                e.addr = model_addr(start, len, size, burst, i);
                e.data = d;
                e.strb = s;
                e.cyc  = hs;
                exp_mem.push_back(e);
            end
            if (last != (i == len)) err = 1'b1;
        end
        exp_b.push_back(err ? 2'b10 : 2'b00);
        do_b(bdelay);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        int size;
        int len;
        int r;
        rstn      = 1'b0;
        i_awaddr  = 12'h000;
        i_awlen   = 8'd0;
        i_awsize  = 3'd0;
        i_awburst = 2'b00;
        i_awvalid = 1'b0;
        i_wdata   = 32'h0;
        i_wstrb   = 4'h0;
        i_wlast   = 1'b0;
        i_wvalid  = 1'b0;
        i_bready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("awready_after_reset", 64'(o_awready), 64'd1);
        @(posedge clk);
        #1;

        run_burst(12'h010, 3, 2, 1, 0, 0, -1, -1);   // INCR
        run_burst(12'h078, 7, 2, 2, 0, 0, -1, -1);   // WRAP
        run_burst(12'h040, 2, 2, 0, 3, 0, -1, -1);   // FIXED with gaps
        run_burst(12'h000, 3, 3, 1, 0, 0, -1, -1);   // oversize beat
        run_burst(12'h020, 3, 2, 1, 0, 0, 1, -1);    // early wlast
        run_burst(12'h200, 1, 2, 1, 0, 5, -1, -1);   // B backpressure
        run_burst(12'hFF8, 3, 2, 1, 0, 0, -1, -1);   // top-of-range wrap
        run_burst(12'h300, 3, 2, 1, 0, 0, -1, 2);    // reset mid-burst
        run_burst(12'h100, 3, 2, 1, 0, 0, -1, -1);   // clean burst after reset
        run_burst(12'hF81, 255, 0, 1, 0, 1, -1, -1); // 256 beats, unaligned
        run_burst(12'h402, 3, 1, 3, 0, 0, -1, -1);   // reserved burst
        run_burst(12'h500, 5, 2, 2, 0, 0, -1, -1);   // illegal WRAP length

        for (int k = 0; k < 40; k++) begin
            r     = $urandom_range(15, 0);
            burst = (r == 0) ? 3 : (r % 3);
            size  = ($urandom_range(9, 0) == 0) ? 3 : $urandom_range(2, 0);
            if (burst == 2 && $urandom_range(7, 0) != 0) begin
                r   = $urandom_range(3, 0);
                len = (2 << r) - 1;
            end else begin
                len = $urandom_range(15, 0);
            end
            run_burst($urandom_range(4095, 0), len, size, burst, -1, $urandom_range(3, 0),
                      ($urandom_range(7, 0) == 0) ? $urandom_range(len, 0) : -1, -1);
        end

        repeat (4) @(posedge clk);
        chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
